// File: rtl/arm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer: FSM state
// encoding, word size in bytes and the four addressing-mode codes.
package arm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  // Addressing-mode code is simply {P, U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } am_mode_t;

  localparam int WORD_BYTES = 4;
  localparam int PC_INDEX   = 15;

  function automatic am_mode_t mode_of(input logic pre_index, input logic up);
    return am_mode_t'({pre_index, up});
  endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Priority finder: index of the least-significant set bit of a mask, plus a
// flag saying whether any bit is set at all. Purely combinational.
module lowest_set_bit #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) index = IDX_W'(i);
    end
  end

  assign valid = |mask;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle LDM/STM initiator. Latches a block-transfer command, walks the
// register list lowest register first (always at the lowest address), issues
// one memory beat per listed register, then optionally writes back the base.
module ldm_stm_sequencer
  import arm_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  pre_index,
  input  logic                  up,
  input  logic                  writeback,
  input  logic [NUM_REGS-1:0]   reg_list,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_val,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [WORD_SIZE-1:0]  rf_read_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic                  mem_ready,
  input  logic [WORD_SIZE-1:0]  mem_rdata
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(WORD_BYTES);

  seq_state_t            state;
  logic [NUM_REGS-1:0]   mask_q;
  logic [WORD_SIZE-1:0]  cur_addr;
  logic [WORD_SIZE-1:0]  wb_val;
  logic [ADDR_WIDTH-1:0] base_reg_q;
  logic                  is_load_q;
  logic                  writeback_q;
  logic                  base_loaded;

  logic [CNT_W-1:0]      start_count;
  logic [WORD_SIZE-1:0]  span;
  logic [WORD_SIZE-1:0]  start_addr;
  logic [ADDR_WIDTH-1:0] cur_reg;
  logic                  cur_valid;
  logic [NUM_REGS-1:0]   mask_next;
  logic                  beat;
  logic                  cur_is_pc;
  logic                  wb_write;

  lowest_set_bit #(
    .WIDTH (NUM_REGS),
    .IDX_W (ADDR_WIDTH)
  ) u_lsb (
    .mask  (mask_q),
    .index (cur_reg),
    .valid (cur_valid)
  );

  // Number of registers in the incoming list
  always_comb begin
    start_count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      start_count = start_count + CNT_W'(reg_list[i]);
    end
  end

  assign span = WORD_SIZE'(start_count) * STEP;

  // First beat address for each addressing mode, modulo 2^WORD_SIZE
  always_comb begin
    case (mode_of(pre_index, up))
      MODE_IA: start_addr = base_val;
      MODE_IB: start_addr = base_val + STEP;
      MODE_DA: start_addr = base_val - span + STEP;
      default: start_addr = base_val - span;
    endcase
  end

  assign beat      = (state == S_XFER) && mem_req && mem_ready && cur_valid;
  assign cur_is_pc = (cur_reg == ADDR_WIDTH'(PC_INDEX));
  assign mask_next = mask_q & ~(NUM_REGS'(1) << cur_reg);
  assign wb_write  = (state == S_WB) && writeback_q && !(is_load_q && base_loaded);

  assign stall        = busy;
  assign mem_we       = mem_req && !is_load_q;
  assign mem_addr     = mem_req ? cur_addr : '0;
  assign rf_read_addr = mem_we ? cur_reg : '0;
  assign mem_wdata    = mem_we ? rf_read_data : '0;
  assign pc_we        = beat && is_load_q && cur_is_pc;
  assign pc_in        = pc_we ? (mem_rdata & ~WORD_SIZE'(3)) : '0;
  assign rf_we        = (beat && is_load_q && !cur_is_pc) || wb_write;

  // Register-file write port: loaded data during a load beat, else base writeback
  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    if (beat && is_load_q && !cur_is_pc) begin
      rf_waddr = cur_reg;
      rf_wdata = mem_rdata;
    end else if (wb_write) begin
      rf_waddr = base_reg_q;
      rf_wdata = wb_val;
    end
  end

  // Sequencer FSM with registered busy/done/mem_req; reset aborts at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      cur_addr    <= '0;
      wb_val      <= '0;
      base_reg_q  <= '0;
      is_load_q   <= 1'b0;
      writeback_q <= 1'b0;
      base_loaded <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_req     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_q      <= reg_list;
            cur_addr    <= start_addr;
            wb_val      <= up ? (base_val + span) : (base_val - span);
            base_reg_q  <= base_reg;
            is_load_q   <= is_load;
            writeback_q <= writeback;
            base_loaded <= 1'b0;
            busy        <= 1'b1;
            if (start_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_XFER;
              mem_req <= 1'b1;
            end
          end
        end
        S_XFER: begin
          if (beat) begin
            mask_q   <= mask_next;
            cur_addr <= cur_addr + STEP;
            if (is_load_q && (cur_reg == base_reg_q)) base_loaded <= 1'b1;
            if (mask_next == '0) begin
              state   <= S_WB;
              mem_req <= 1'b0;
            end
          end
        end
        S_WB: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: a table of block-transfer
// commands with hand-computed addresses, beat counts, writeback and done
// timing, plus hand-written memory-stall and mid-operation reset sequences.
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        pre_index;
  logic        up;
  logic        writeback;
  logic [15:0] reg_list;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic        busy;
  logic        stall;
  logic        done;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_we;
  logic [31:0] pc_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [31:0] rf_model [16];

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic        is_load;
    logic        pre;
    logic        up;
    logic        wb;
    logic [15:0] list;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [31:0] exp_first;
    int          exp_beats;
    logic        exp_wb;
    logic [31:0] exp_wb_val;
    int          exp_done_cyc;
    logic        pulse_start;
  } vec_t;

  vec_t vecs[11];

  ldm_stm_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_load      (is_load),
    .pre_index    (pre_index),
    .up           (up),
    .writeback    (writeback),
    .reg_list     (reg_list),
    .base_reg     (base_reg),
    .base_val     (base_val),
    .busy         (busy),
    .stall        (stall),
    .done         (done),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pc_we        (pc_we),
    .pc_in        (pc_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file and memory environment: fixed register contents, memory word = address + 0x5A000003
  assign rf_read_data = rf_model[rf_read_addr];
  assign mem_rdata    = mem_addr + 32'h5A00_0003;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a + 32'h5A00_0003;
  endfunction

  function automatic logic [3:0] firstReg(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        r = 4'(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " stall"}, 32'(stall), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, " mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, " rf_read_addr"}, 32'(rf_read_addr), 32'd0);
    checkOutput({tag, " rf_we"}, 32'(rf_we), 32'd0);
    checkOutput({tag, " rf_waddr"}, 32'(rf_waddr), 32'd0);
    checkOutput({tag, " rf_wdata"}, rf_wdata, 32'd0);
    checkOutput({tag, " pc_we"}, 32'(pc_we), 32'd0);
    checkOutput({tag, " pc_in"}, pc_in, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    is_load   = v.is_load;
    pre_index = v.pre;
    up        = v.up;
    writeback = v.wb;
    reg_list  = v.list;
    base_reg  = v.base_reg;
    base_val  = v.base_val;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    int          k;
    logic [15:0] rem;
    logic [3:0]  er;
    logic        seen_wb;
    logic        finished;
    logic [31:0] ea;
    applyStimulus(v);
    rem      = v.list;
    k        = 0;
    seen_wb  = 1'b0;
    finished = 1'b0;
    for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
      if (v.pulse_start && cyc == 1) begin
        start    = 1'b1;
        is_load  = ~v.is_load;
        reg_list = 16'hFFFF;
      end else begin
        start    = 1'b0;
      end
      checkOutput({v.name, " busy"}, 32'(busy), 32'd1);
      checkOutput({v.name, " stall"}, 32'(stall), 32'd1);
      checkOutput({v.name, " we_exclusive"}, 32'(rf_we & pc_we), 32'd0);
      if (mem_req) begin
        er = firstReg(rem);
        ea = v.exp_first + 32'(4 * k);
        checkOutput({v.name, " mem_addr"}, mem_addr, ea);
        checkOutput({v.name, " mem_we"}, 32'(mem_we), 32'(!v.is_load));
        if (!v.is_load) begin
          checkOutput({v.name, " rf_read_addr"}, 32'(rf_read_addr), 32'(er));
          checkOutput({v.name, " mem_wdata"}, mem_wdata, rf_model[er]);
        end else if (er == 4'd15) begin
          checkOutput({v.name, " pc_we"}, 32'(pc_we), 32'd1);
          checkOutput({v.name, " pc_in"}, pc_in, memWord(ea) & 32'hFFFF_FFFC);
          checkOutput({v.name, " rf_we_on_pc"}, 32'(rf_we), 32'd0);
        end else begin
          checkOutput({v.name, " rf_we"}, 32'(rf_we), 32'd1);
          checkOutput({v.name, " rf_waddr"}, 32'(rf_waddr), 32'(er));
          checkOutput({v.name, " rf_wdata"}, rf_wdata, memWord(ea));
        end
        rem[er] = 1'b0;
        k++;
      end else if (done) begin
        checkOutput({v.name, " done_cycle"}, 32'(cyc), 32'(v.exp_done_cyc));
        checkOutput({v.name, " beats"}, 32'(k), 32'(v.exp_beats));
        checkOutput({v.name, " wb_seen"}, 32'(seen_wb), 32'(v.exp_wb));
        checkOutput({v.name, " done_rf_we"}, 32'(rf_we), 32'd0);
        finished = 1'b1;
      end else begin
        checkOutput({v.name, " wb_rf_we"}, 32'(rf_we), 32'(v.exp_wb));
        if (v.exp_wb) begin
          checkOutput({v.name, " wb_waddr"}, 32'(rf_waddr), 32'(v.base_reg));
          checkOutput({v.name, " wb_wdata"}, rf_wdata, v.exp_wb_val);
        end
        seen_wb = seen_wb | rf_we;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: done not seen within 60 cycles", v.name);
    end
    checkOutput({v.name, " idle_busy"}, 32'(busy), 32'd0);
    checkOutput({v.name, " idle_done"}, 32'(done), 32'd0);
    checkOutput({v.name, " idle_mem_req"}, 32'(mem_req), 32'd0);
  endtask

  // Memory holds off three cycles mid-STM, then reset lands between clock edges
  task automatic stallAndReset();
    @(negedge clk);
    is_load   = 1'b0;
    pre_index = 1'b0;
    up        = 1'b1;
    writeback = 1'b1;
    reg_list  = 16'h0006;
    base_reg  = 4'd0;
    base_val  = 32'h0000_0080;
    mem_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall mem_req", 32'(mem_req), 32'd1);
      checkOutput("stall mem_addr", mem_addr, 32'h0000_0080);
      checkOutput("stall mem_wdata", mem_wdata, rf_model[1]);
      checkOutput("stall rf_read_addr", 32'(rf_read_addr), 32'd1);
      if (i == 2) mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    checkOutput("stall second addr", mem_addr, 32'h0000_0084);
    checkOutput("stall second wdata", mem_wdata, rf_model[2]);
    checkOutput("stall still busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkAllZero("after_reset");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_load   = 1'b0;
    pre_index = 1'b0;
    up        = 1'b0;
    writeback = 1'b0;
    reg_list  = 16'h0000;
    base_reg  = 4'd0;
    base_val  = 32'h0;
    mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) rf_model[i] = 32'hA000_0000 + 32'(i);

    //           name            ld P  U  W  list      rb     base          first         n  wb  wb_val        done pulse
    vecs[0]  = '{"STMIA",        0, 0, 1, 0, 16'h000E, 4'd0,  32'h0000_0100, 32'h0000_0100, 3, 0, 32'h0,         5, 0};
    vecs[1]  = '{"LDMDB_W",      1, 1, 0, 1, 16'h0030, 4'd4,  32'h0000_0200, 32'h0000_01F8, 2, 0, 32'h0,         4, 0};
    vecs[2]  = '{"STMDA_W",      0, 0, 0, 1, 16'h0101, 4'd1,  32'h0000_0300, 32'h0000_02FC, 2, 1, 32'h0000_02F8, 4, 0};
    vecs[3]  = '{"STMIB_W",      0, 1, 1, 1, 16'h00F0, 4'd3,  32'h0000_0400, 32'h0000_0404, 4, 1, 32'h0000_0410, 6, 0};
    vecs[4]  = '{"LDMIA_W",      1, 0, 1, 1, 16'h0006, 4'd13, 32'h0000_1000, 32'h0000_1000, 2, 1, 32'h0000_1008, 4, 0};
    vecs[5]  = '{"EMPTY_LIST",   0, 0, 1, 1, 16'h0000, 4'd5,  32'h0000_0050, 32'h0000_0050, 0, 0, 32'h0,         1, 0};
    vecs[6]  = '{"STMDB_WRAP",   0, 1, 0, 1, 16'h0003, 4'd2,  32'h0000_0004, 32'hFFFF_FFFC, 2, 1, 32'hFFFF_FFFC, 4, 0};
    vecs[7]  = '{"LDMIA_PC",     1, 0, 1, 0, 16'h8001, 4'd0,  32'h0000_2000, 32'h0000_2000, 2, 0, 32'h0,         4, 0};
    vecs[8]  = '{"LDMIA_BASEIN", 1, 0, 1, 1, 16'h0007, 4'd2,  32'h0000_3000, 32'h0000_3000, 3, 0, 32'h0,         5, 0};
    vecs[9]  = '{"START_BUSY",   0, 0, 1, 0, 16'h0003, 4'd0,  32'h0000_0600, 32'h0000_0600, 2, 0, 32'h0,         4, 1};
    vecs[10] = '{"LDMIB",        1, 1, 1, 0, 16'h0840, 4'd7,  32'h0000_0700, 32'h0000_0704, 2, 0, 32'h0,         4, 0};

    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("post_reset_idle");

    for (int i = 0; i < 11; i++) runVector(vecs[i]);

    stallAndReset();
    runVector(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

endmodule
